// File: rtl/ariane_pkg.sv
// Shared types for the TLB miss arbiter: Sv32 TLB fill record and arbiter FSM states.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_4M;
        logic [19:0] vpn;
        logic [8:0]  asid;
        logic [31:0] content;
    } tlb_update_sv32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/riscv_pkg.sv
// Architectural constants for the Sv32 (RV32) configuration.
package riscv;

    localparam int unsigned VLEN = 32;

endpackage

// File: rtl/tlb_rr_arb2.sv
// Two-way ITLB/DTLB grant logic with last-grant pointer.
// TLB_ARB_DTLB_PRIORITY_EN selects fixed DTLB-first priority instead of round-robin.
module tlb_rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic itlb_req_i,
    input  logic dtlb_req_i,
    input  logic en_i,
    output logic gnt_valid_o,
    output logic gnt_dtlb_o
);

    assign gnt_valid_o = en_i & (itlb_req_i | dtlb_req_i);

`ifdef TLB_ARB_DTLB_PRIORITY_EN
    logic unused_clk_rst;

    assign unused_clk_rst = clk_i ^ rst_i;
    assign gnt_dtlb_o     = dtlb_req_i;
`else
    logic last_dtlb_q, last_dtlb_d;

    // On a tie the requester that did not win last time is granted.
    assign gnt_dtlb_o = dtlb_req_i & (~itlb_req_i | ~last_dtlb_q);

    always_comb begin
        last_dtlb_d = last_dtlb_q;
        if (gnt_valid_o) begin
            last_dtlb_d = gnt_dtlb_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dtlb_q <= 1'b1;
        end else begin
            last_dtlb_q <= last_dtlb_d;
        end
    end
`endif

endmodule

// File: rtl/tlb_miss_arbiter_sv32.sv
// Arbitrates ITLB/DTLB misses onto a single page-table walker with flush and watchdog handling.
// Build option: TLB_ARB_DTLB_PRIORITY_EN (fixed DTLB priority, see tlb_rr_arb2).
module tlb_miss_arbiter_sv32
    import ariane_pkg::*;
#(
    parameter int unsigned ASID_WIDTH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   itlb_req_i,
    input  logic                   dtlb_req_i,
    input  logic [riscv::VLEN-1:0] itlb_vaddr_i,
    input  logic [riscv::VLEN-1:0] dtlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0]  itlb_asid_i,
    input  logic [ASID_WIDTH-1:0]  dtlb_asid_i,
    output logic                   itlb_ack_o,
    output logic                   dtlb_ack_o,
    output logic                   itlb_err_o,
    output logic                   dtlb_err_o,
    output tlb_update_sv32_t       itlb_update_o,
    output tlb_update_sv32_t       dtlb_update_o,
    output logic                   ptw_valid_o,
    input  logic                   ptw_ready_i,
    output logic [riscv::VLEN-1:0] ptw_vaddr_o,
    output logic [ASID_WIDTH-1:0]  ptw_asid_o,
    output logic                   ptw_is_instr_o,
    input  logic                   ptw_done_i,
    input  logic                   ptw_error_i,
    input  tlb_update_sv32_t       ptw_update_i
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [riscv::VLEN-1:0] vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0]  asid_q, asid_d;
    logic                   is_instr_q, is_instr_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   itlb_ack_q, itlb_ack_d;
    logic                   dtlb_ack_q, dtlb_ack_d;
    logic                   itlb_err_q, itlb_err_d;
    logic                   dtlb_err_q, dtlb_err_d;
    tlb_update_sv32_t       itlb_update_q, itlb_update_d;
    tlb_update_sv32_t       dtlb_update_q, dtlb_update_d;

    logic grant_en;
    logic gnt_valid;
    logic gnt_dtlb;

    // The requester still holds req during its ack cycle, so granting then would replay it.
    assign grant_en = (state_q == IDLE) & ~flush_i & ~itlb_ack_q & ~dtlb_ack_q;

    tlb_rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .itlb_req_i  (itlb_req_i),
        .dtlb_req_i  (dtlb_req_i),
        .en_i        (grant_en),
        .gnt_valid_o (gnt_valid),
        .gnt_dtlb_o  (gnt_dtlb)
    );

    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        asid_d        = asid_q;
        is_instr_d    = is_instr_q;
        wdog_d        = wdog_q;
        itlb_ack_d    = 1'b0;
        dtlb_ack_d    = 1'b0;
        itlb_err_d    = 1'b0;
        dtlb_err_d    = 1'b0;
        itlb_update_d = '0;
        dtlb_update_d = '0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    vaddr_d    = gnt_dtlb ? dtlb_vaddr_i : itlb_vaddr_i;
                    asid_d     = gnt_dtlb ? dtlb_asid_i : itlb_asid_i;
                    is_instr_d = ~gnt_dtlb;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A flush racing the handshake still has to wait out the started walk.
                if (ptw_ready_i) begin
                    wdog_d  = '0;
                    state_d = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = ptw_done_i ? IDLE : DRAIN;
                end else if (ptw_done_i) begin
                    state_d = IDLE;
                    if (is_instr_q) begin
                        itlb_ack_d          = 1'b1;
                        itlb_err_d          = ptw_error_i;
                        itlb_update_d       = ptw_update_i;
                        itlb_update_d.valid = ~ptw_error_i;
                    end else begin
                        dtlb_ack_d          = 1'b1;
                        dtlb_err_d          = ptw_error_i;
                        dtlb_update_d       = ptw_update_i;
                        dtlb_update_d.valid = ~ptw_error_i;
                    end
                end else if (wdog_q == WD_LAST) begin
                    state_d    = DRAIN;
                    itlb_ack_d = is_instr_q;
                    itlb_err_d = is_instr_q;
                    dtlb_ack_d = ~is_instr_q;
                    dtlb_err_d = ~is_instr_q;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DRAIN: begin
                if (ptw_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            vaddr_q       <= '0;
            asid_q        <= '0;
            is_instr_q    <= 1'b0;
            wdog_q        <= '0;
            itlb_ack_q    <= 1'b0;
            dtlb_ack_q    <= 1'b0;
            itlb_err_q    <= 1'b0;
            dtlb_err_q    <= 1'b0;
            itlb_update_q <= '0;
            dtlb_update_q <= '0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            asid_q        <= asid_d;
            is_instr_q    <= is_instr_d;
            wdog_q        <= wdog_d;
            itlb_ack_q    <= itlb_ack_d;
            dtlb_ack_q    <= dtlb_ack_d;
            itlb_err_q    <= itlb_err_d;
            dtlb_err_q    <= dtlb_err_d;
            itlb_update_q <= itlb_update_d;
            dtlb_update_q <= dtlb_update_d;
        end
    end

    assign ptw_valid_o    = (state_q == REQ);
    assign ptw_vaddr_o    = vaddr_q;
    assign ptw_asid_o     = asid_q;
    assign ptw_is_instr_o = is_instr_q;
    assign itlb_ack_o     = itlb_ack_q;
    assign dtlb_ack_o     = dtlb_ack_q;
    assign itlb_err_o     = itlb_err_q;
    assign dtlb_err_o     = dtlb_err_q;
    assign itlb_update_o  = itlb_update_q;
    assign dtlb_update_o  = dtlb_update_q;

endmodule

// File: tb/tb_tlb_miss_arbiter_sv32.sv
// Scoreboard bench for tlb_miss_arbiter_sv32: directed vectors push expected walks/acks, a monitor pops and compares.
module tb_tlb_miss_arbiter_sv32;
    import ariane_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned TO = 16;
`ifdef TLB_ARB_DTLB_PRIORITY_EN
    localparam bit DTLB_FIRST = 1'b1;
`else
    localparam bit DTLB_FIRST = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             itlb_req_i = 1'b0, dtlb_req_i = 1'b0;
    logic [31:0]      itlb_vaddr_i = '0, dtlb_vaddr_i = '0;
    logic [AW-1:0]    itlb_asid_i = '0, dtlb_asid_i = '0;
    logic             itlb_ack_o, dtlb_ack_o, itlb_err_o, dtlb_err_o;
    tlb_update_sv32_t itlb_update_o, dtlb_update_o;
    logic             ptw_valid_o;
    logic             ptw_ready_i = 1'b1;
    logic [31:0]      ptw_vaddr_o;
    logic [AW-1:0]    ptw_asid_o;
    logic             ptw_is_instr_o;
    logic             ptw_done_i = 1'b0, ptw_error_i = 1'b0;
    tlb_update_sv32_t ptw_update_i = '0;

    tlb_miss_arbiter_sv32 #(.ASID_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .itlb_req_i(itlb_req_i), .dtlb_req_i(dtlb_req_i),
        .itlb_vaddr_i(itlb_vaddr_i), .dtlb_vaddr_i(dtlb_vaddr_i),
        .itlb_asid_i(itlb_asid_i), .dtlb_asid_i(dtlb_asid_i),
        .itlb_ack_o(itlb_ack_o), .dtlb_ack_o(dtlb_ack_o),
        .itlb_err_o(itlb_err_o), .dtlb_err_o(dtlb_err_o),
        .itlb_update_o(itlb_update_o), .dtlb_update_o(dtlb_update_o),
        .ptw_valid_o(ptw_valid_o), .ptw_ready_i(ptw_ready_i),
        .ptw_vaddr_o(ptw_vaddr_o), .ptw_asid_o(ptw_asid_o), .ptw_is_instr_o(ptw_is_instr_o),
        .ptw_done_i(ptw_done_i), .ptw_error_i(ptw_error_i), .ptw_update_i(ptw_update_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] vaddr; logic [AW-1:0] asid; logic instr; } walk_t;
    typedef struct { logic dtlb; logic err; tlb_update_sv32_t upd; } ack_t;

    walk_t walk_q[$];
    ack_t  ack_q[$];
    walk_t w_exp;
    ack_t  a_exp;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic tlb_update_sv32_t mk_upd(input logic [19:0] vpn, input logic [8:0] asid,
                                                input logic [31:0] content);
        tlb_update_sv32_t u;
        u.valid   = 1'b1;
        u.is_4M   = 1'b0;
        u.vpn     = vpn;
        u.asid    = asid;
        u.content = content;
        return u;
    endfunction

    function automatic tlb_update_sv32_t exp_upd(input tlb_update_sv32_t u, input logic err);
        tlb_update_sv32_t r;
        r       = u;
        r.valid = ~err;
        return r;
    endfunction

    function automatic logic [9:0] quiet_vec();
        return {itlb_ack_o, dtlb_ack_o, itlb_err_o, dtlb_err_o, |itlb_update_o, |dtlb_update_o,
                ptw_valid_o, ptw_is_instr_o, |ptw_vaddr_o, |ptw_asid_o};
    endfunction

    // Monitor: every handshake and every ack is matched against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ptw_valid_o && ptw_ready_i) begin
                if (walk_q.size() == 0) begin
                    check("walk_unexpected", 64'(1), 64'(0));
                end else begin
                    w_exp = walk_q.pop_front();
                    check("walk_vaddr", 64'(ptw_vaddr_o), 64'(w_exp.vaddr));
                    check("walk_asid", 64'(ptw_asid_o), 64'(w_exp.asid));
                    check("walk_is_instr", 64'(ptw_is_instr_o), 64'(w_exp.instr));
                end
            end
            if (itlb_ack_o || dtlb_ack_o) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 64'({itlb_ack_o, dtlb_ack_o}), 64'(0));
                end else begin
                    a_exp = ack_q.pop_front();
                    check("ack_side", 64'({itlb_ack_o, dtlb_ack_o}), a_exp.dtlb ? 64'(2'b01) : 64'(2'b10));
                    check("ack_err", 64'(a_exp.dtlb ? dtlb_err_o : itlb_err_o), 64'(a_exp.err));
                    check("ack_update", 64'(a_exp.dtlb ? dtlb_update_o : itlb_update_o), 64'(a_exp.upd));
                    check("nonowner_quiet", a_exp.dtlb ? 64'({itlb_err_o, itlb_update_o})
                                                       : 64'({dtlb_err_o, dtlb_update_o}), 64'(0));
                end
            end else begin
                check("no_ack_quiet", 64'({itlb_err_o, dtlb_err_o, itlb_update_o.valid, dtlb_update_o.valid}),
                      64'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk_i);
        while (!ptw_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_valid_seen"}, 64'(ptw_valid_o), 64'(1));
    endtask

    task automatic pulse_done(input logic err, input tlb_update_sv32_t u);
        ptw_done_i   = 1'b1;
        ptw_error_i  = err;
        ptw_update_i = u;
        tick();
        ptw_done_i   = 1'b0;
        ptw_error_i  = 1'b0;
        ptw_update_i = '0;
    endtask

    task automatic do_reset(input string name);
        rst_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        check({name, "_outputs_zero"}, 64'(quiet_vec()), 64'(0));
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        tlb_update_sv32_t u;
        tlb_update_sv32_t u2;
        int n;

        do_reset("reset");

        // Single ITLB walk, done in the 5th WAIT cycle.
        u = mk_upd(20'h80001, 9'h001, 32'h2000_04CF);
        itlb_vaddr_i = 32'h8000_1000; itlb_asid_i = 9'h001;
        walk_q.push_back('{32'h8000_1000, 9'h001, 1'b1});
        itlb_req_i = 1'b1;
        wait_valid("t1");
        tick();
        repeat (4) tick();
        ack_q.push_back('{1'b0, 1'b0, exp_upd(u, 1'b0)});
        pulse_done(1'b0, u);
        @(negedge clk_i);
        check("t1_ack_one_cycle_after_done", 64'({itlb_ack_o, dtlb_ack_o, itlb_update_o.valid}), 64'(3'b101));
        tick();
        itlb_req_i = 1'b0;
        @(negedge clk_i);
        check("t1_no_regrant_in_ack_cycle", 64'(ptw_valid_o), 64'(0));

        // Simultaneous requests right after reset; second walk faults.
        do_reset("reset2");
        u  = mk_upd(20'h00001, 9'h011, 32'h0000_10CF);
        u2 = mk_upd(20'h00002, 9'h022, 32'h0000_20CF);
        itlb_vaddr_i = 32'h0000_1000; itlb_asid_i = 9'h011;
        dtlb_vaddr_i = 32'h0000_2000; dtlb_asid_i = 9'h022;
        if (DTLB_FIRST) begin
            walk_q.push_back('{32'h0000_2000, 9'h022, 1'b0});
            walk_q.push_back('{32'h0000_1000, 9'h011, 1'b1});
        end else begin
            walk_q.push_back('{32'h0000_1000, 9'h011, 1'b1});
            walk_q.push_back('{32'h0000_2000, 9'h022, 1'b0});
        end
        itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
        wait_valid("t2a");
        tick();
        repeat (2) tick();
        ack_q.push_back('{DTLB_FIRST, 1'b0, exp_upd(DTLB_FIRST ? u2 : u, 1'b0)});
        pulse_done(1'b0, DTLB_FIRST ? u2 : u);
        @(negedge clk_i);
        check("t2_first_winner", 64'({itlb_ack_o, dtlb_ack_o}), DTLB_FIRST ? 64'(2'b01) : 64'(2'b10));
        tick();
        if (DTLB_FIRST) dtlb_req_i = 1'b0; else itlb_req_i = 1'b0;
        wait_valid("t2b");
        tick();
        tick();
        ack_q.push_back('{!DTLB_FIRST, 1'b1, exp_upd(DTLB_FIRST ? u : u2, 1'b1)});
        pulse_done(1'b1, DTLB_FIRST ? u : u2);
        @(negedge clk_i);
        tick();
        itlb_req_i = 1'b0; dtlb_req_i = 1'b0;

        // DTLB walk with page fault.
        u = mk_upd(20'h00403, 9'h005, 32'h0000_0001);
        dtlb_vaddr_i = 32'h0040_3000; dtlb_asid_i = 9'h005;
        walk_q.push_back('{32'h0040_3000, 9'h005, 1'b0});
        dtlb_req_i = 1'b1;
        wait_valid("t3");
        tick();
        tick();
        ack_q.push_back('{1'b1, 1'b1, exp_upd(u, 1'b1)});
        pulse_done(1'b1, u);
        @(negedge clk_i);
        check("t3_fault_ack_err_novalid", 64'({dtlb_ack_o, dtlb_err_o, dtlb_update_o.valid}), 64'(3'b110));
        tick();
        dtlb_req_i = 1'b0;
        tick();

        // Flush during WAIT, done three cycles later; pending ITLB then granted.
        u = mk_upd(20'h00005, 9'h007, 32'h0000_50CF);
        dtlb_vaddr_i = 32'h0000_3000; dtlb_asid_i = 9'h003;
        walk_q.push_back('{32'h0000_3000, 9'h003, 1'b0});
        dtlb_req_i = 1'b1;
        wait_valid("t4");
        tick();
        flush_i = 1'b1; dtlb_req_i = 1'b0;
        itlb_vaddr_i = 32'h0000_5000; itlb_asid_i = 9'h007; itlb_req_i = 1'b1;
        tick();
        flush_i = 1'b0;
        walk_q.push_back('{32'h0000_5000, 9'h007, 1'b1});
        @(negedge clk_i);
        check("t4_drain_no_valid_a", 64'(ptw_valid_o), 64'(0));
        tick();
        @(negedge clk_i);
        check("t4_drain_no_valid_b", 64'(ptw_valid_o), 64'(0));
        tick();
        pulse_done(1'b0, mk_upd(20'h00003, 9'h003, 32'hDEAD_BEEF));
        @(negedge clk_i);
        check("t4_idle_after_done", 64'({ptw_valid_o, itlb_ack_o, dtlb_ack_o}), 64'(0));
        @(negedge clk_i);
        check("t4_pending_itlb_granted", 64'(ptw_valid_o), 64'(1));
        tick();
        ack_q.push_back('{1'b0, 1'b0, exp_upd(u, 1'b0)});
        pulse_done(1'b0, u);
        @(negedge clk_i);
        tick();
        itlb_req_i = 1'b0;
        tick();

        // Flush coincident with done: no ack, no update.
        itlb_vaddr_i = 32'h0000_6000; itlb_asid_i = 9'h006;
        walk_q.push_back('{32'h0000_6000, 9'h006, 1'b1});
        itlb_req_i = 1'b1;
        wait_valid("t5");
        tick();
        tick();
        flush_i = 1'b1; itlb_req_i = 1'b0;
        pulse_done(1'b0, mk_upd(20'h00006, 9'h006, 32'h0000_60CF));
        flush_i = 1'b0;
        @(negedge clk_i);
        check("t5_flush_wins_over_done", 64'({itlb_ack_o, itlb_update_o.valid, ptw_valid_o}), 64'(0));
        tick();

        // Flush in IDLE blocks the grant; flush in REQ before handshake returns to IDLE.
        ptw_ready_i = 1'b0;
        itlb_vaddr_i = 32'h0000_7000; itlb_asid_i = 9'h00F;
        itlb_req_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("t6_flush_blocks_grant", 64'(ptw_valid_o), 64'(0));
        tick();
        @(negedge clk_i);
        check("t6_grant_after_flush", 64'({ptw_valid_o, ptw_vaddr_o}), 64'({1'b1, 32'h0000_7000}));
        tick();
        flush_i = 1'b1; itlb_req_i = 1'b0;
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("t6_flush_in_req", 64'(ptw_valid_o), 64'(0));
        ptw_ready_i = 1'b1;
        tick();

        // Watchdog: no done -> ack+err after the 16th WAIT cycle, DRAIN until late done.
        dtlb_vaddr_i = 32'h0000_9000; dtlb_asid_i = 9'h1AB;
        walk_q.push_back('{32'h0000_9000, 9'h1AB, 1'b0});
        dtlb_req_i = 1'b1;
        wait_valid("t7");
        tick();
        ack_q.push_back('{1'b1, 1'b1, tlb_update_sv32_t'('0)});
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!dtlb_ack_o && n < 40);
        check("t7_timeout_cycle", 64'(n), 64'(TO + 1));
        tick();
        dtlb_req_i = 1'b0;
        itlb_vaddr_i = 32'h0000_A000; itlb_asid_i = 9'h00A; itlb_req_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("t7_drain_no_grant", 64'(ptw_valid_o), 64'(0));
            tick();
        end
        walk_q.push_back('{32'h0000_A000, 9'h00A, 1'b1});
        pulse_done(1'b0, mk_upd(20'h00009, 9'h1AB, 32'h0BAD_0BAD));
        @(negedge clk_i);
        check("t7_late_done_discarded", 64'({dtlb_ack_o, dtlb_update_o.valid, ptw_valid_o}), 64'(0));
        @(negedge clk_i);
        check("t7_grant_after_drain", 64'(ptw_valid_o), 64'(1));
        tick();
        u = mk_upd(20'h0000A, 9'h00A, 32'h0000_A0CF);
        ack_q.push_back('{1'b0, 1'b0, exp_upd(u, 1'b0)});
        pulse_done(1'b0, u);
        @(negedge clk_i);
        tick();
        itlb_req_i = 1'b0;
        tick();

        // Requester drops req mid-walk: result still delivered exactly once.
        u = mk_upd(20'h0000B, 9'h00B, 32'h0000_B0CF);
        itlb_vaddr_i = 32'h0000_B000; itlb_asid_i = 9'h00B;
        walk_q.push_back('{32'h0000_B000, 9'h00B, 1'b1});
        itlb_req_i = 1'b1;
        wait_valid("t8");
        tick();
        itlb_req_i = 1'b0;
        tick();
        ack_q.push_back('{1'b0, 1'b0, exp_upd(u, 1'b0)});
        pulse_done(1'b0, u);
        @(negedge clk_i);
        check("t8_ack_after_drop", 64'(itlb_ack_o), 64'(1));
        @(negedge clk_i);
        check("t8_ack_once", 64'(itlb_ack_o), 64'(0));
        tick();

        // Reset mid-walk drops it without ack.
        dtlb_vaddr_i = 32'h0000_C000; dtlb_asid_i = 9'h00C;
        walk_q.push_back('{32'h0000_C000, 9'h00C, 1'b0});
        dtlb_req_i = 1'b1;
        wait_valid("t9");
        tick();
        tick();
        dtlb_req_i = 1'b0;
        do_reset("t9_reset_mid_walk");
        repeat (4) tick();
        @(negedge clk_i);
        check("t9_no_ack_after_reset", 64'(quiet_vec()), 64'(0));

        check("walk_queue_drained", 64'(walk_q.size()), 64'(0));
        check("ack_queue_drained", 64'(ack_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
